// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared width, counter size and FSM encoding for iter_divider
package iter_divider_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - operand and result stream bundle for iter_divider
interface iter_divider_if
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic [WIDTH-1:0]   s_axis_dividend_tdata;
   logic               s_axis_dividend_tvalid;
   logic               s_axis_dividend_tready;
   logic [WIDTH-1:0]   s_axis_divisor_tdata;
   logic               s_axis_divisor_tvalid;
   logic               s_axis_divisor_tready;
   logic [2*WIDTH-1:0] m_axis_dout_tdata;
   logic               m_axis_dout_tvalid;

   modport slave (
      input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
      output s_axis_dividend_tready,
      input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
      output s_axis_divisor_tready,
      output m_axis_dout_tdata, m_axis_dout_tvalid
   );

   modport master (
      output s_axis_dividend_tdata, s_axis_dividend_tvalid,
      input  s_axis_dividend_tready,
      output s_axis_divisor_tdata, s_axis_divisor_tvalid,
      input  s_axis_divisor_tready,
      input  m_axis_dout_tdata, m_axis_dout_tvalid
   );

endinterface

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - radix-2 restoring divider, one quotient bit per clock
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int SIGNED = 0,
   parameter int WIDTH  = DIV_WIDTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   iter_divider_if.slave div_if
);

   state_t           state;
   logic             dividend_captured;
   logic             divisor_captured;
   logic [WIDTH-1:0] dividend_hold;
   logic [WIDTH-1:0] divisor_hold;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs_mag;
   logic             qsign;
   logic             rsign;
   logic [CNT_W-1:0] count;

   function automatic logic sign_of(input logic [WIDTH-1:0] v);
      return (SIGNED != 0) && v[WIDTH-1];
   endfunction

   function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic             dividend_ready;
   logic             divisor_ready;
   logic             dividend_hs;
   logic             divisor_hs;
   logic [WIDTH-1:0] dividend_val;
   logic [WIDTH-1:0] divisor_val;
   logic             start;

   assign dividend_ready = !reset && (state == IDLE) && !dividend_captured;
   assign divisor_ready  = !reset && (state == IDLE) && !divisor_captured;
   assign div_if.s_axis_dividend_tready = dividend_ready;
   assign div_if.s_axis_divisor_tready  = divisor_ready;

   assign dividend_hs  = div_if.s_axis_dividend_tvalid && dividend_ready;
   assign divisor_hs   = div_if.s_axis_divisor_tvalid && divisor_ready;
   // The operand arriving last is taken straight off the bus at the start edge.
   assign dividend_val = dividend_captured ? dividend_hold : div_if.s_axis_dividend_tdata;
   assign divisor_val  = divisor_captured ? divisor_hold : div_if.s_axis_divisor_tdata;
   assign start        = (dividend_captured || dividend_hs) && (divisor_captured || divisor_hs);

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] quo_next;

   // The shifted remainder needs one extra bit; trial is only used when it fits.
   always_comb begin
      rem_shift = {rem, quo[WIDTH-1]};
      trial     = rem_shift[WIDTH-1:0] - dvs_mag;
      if (rem_shift >= {1'b0, dvs_mag}) begin
         rem_next = trial;
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_shift[WIDTH-1:0];
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                     <= IDLE;
         dividend_captured         <= 1'b0;
         divisor_captured          <= 1'b0;
         div_if.m_axis_dout_tvalid <= 1'b0;
         div_if.m_axis_dout_tdata  <= '0;
      end else if (flush) begin
         state                     <= IDLE;
         dividend_captured         <= 1'b0;
         divisor_captured          <= 1'b0;
         div_if.m_axis_dout_tvalid <= 1'b0;
      end else begin
         div_if.m_axis_dout_tvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  quo               <= negate_if(dividend_val, sign_of(dividend_val));
                  dvs_mag           <= negate_if(divisor_val, sign_of(divisor_val));
                  qsign             <= sign_of(dividend_val) ^ sign_of(divisor_val);
                  rsign             <= sign_of(dividend_val);
                  rem               <= '0;
                  count             <= '0;
                  dividend_captured <= 1'b0;
                  divisor_captured  <= 1'b0;
                  state             <= CALC;
               end else begin
                  if (dividend_hs) begin
                     dividend_hold     <= div_if.s_axis_dividend_tdata;
                     dividend_captured <= 1'b1;
                  end
                  if (divisor_hs) begin
                     divisor_hold     <= div_if.s_axis_divisor_tdata;
                     divisor_captured <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem   <= rem_next;
               quo   <= quo_next;
               count <= count + 1'b1;
               if (count == CNT_W'(WIDTH - 1)) begin
                  div_if.m_axis_dout_tdata  <= {negate_if(quo_next, qsign),
                                                negate_if(rem_next, rsign)};
                  div_if.m_axis_dout_tvalid <= 1'b1;
                  state                     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - unsigned and signed iter_divider checked against an arithmetic model
module tb_iter_divider;
   import iter_divider_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flush;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   iter_divider_if #(.WIDTH(DIV_WIDTH)) u_if ();
   iter_divider_if #(.WIDTH(DIV_WIDTH)) s_if ();

   iter_divider #(.SIGNED(0), .WIDTH(DIV_WIDTH)) u_dut (
      .clk(clk), .reset(reset), .flush(flush), .div_if(u_if.slave));
   iter_divider #(.SIGNED(1), .WIDTH(DIV_WIDTH)) s_dut (
      .clk(clk), .reset(reset), .flush(flush), .div_if(s_if.slave));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   // Truncating division; divide by zero yields all-ones magnitude and the dividend as remainder.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      longint      sa, sb, q, r;
      logic [63:0] qv, rv;
      if (!sgn) begin
         if (b == 32'd0) return {32'hFFFF_FFFF, a};
         return {a / b, a % b};
      end
      if (b == 32'd0) return {(a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF), a};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {qv[31:0], rv[31:0]};
   endfunction

   function automatic logic [3:0] readys();
      return {u_if.s_axis_dividend_tready, u_if.s_axis_divisor_tready,
              s_if.s_axis_dividend_tready, s_if.s_axis_divisor_tready};
   endfunction

   function automatic logic [1:0] valids();
      return {u_if.m_axis_dout_tvalid, s_if.m_axis_dout_tvalid};
   endfunction

   task automatic drive_dvd(input logic v, input logic [31:0] d);
      u_if.s_axis_dividend_tvalid = v;
      u_if.s_axis_dividend_tdata  = d;
      s_if.s_axis_dividend_tvalid = v;
      s_if.s_axis_dividend_tdata  = d;
   endtask

   task automatic drive_dvs(input logic v, input logic [31:0] d);
      u_if.s_axis_divisor_tvalid = v;
      u_if.s_axis_divisor_tdata  = d;
      s_if.s_axis_divisor_tvalid = v;
      s_if.s_axis_divisor_tdata  = d;
   endtask

   // Offers both operands together and holds them until every slot accepts.
   task automatic send_both(input logic [31:0] a, input logic [31:0] b, output int e);
      drive_dvd(1'b1, a);
      drive_dvs(1'b1, b);
      for (int i = 0; i < 60; i++) begin
         if (readys() == 4'hF) begin
            @(posedge clk); #1;
            e = cyc;
            drive_dvd(1'b0, '0);
            drive_dvs(1'b0, '0);
            return;
         end
         @(posedge clk); #1;
      end
      check("send_timeout", 1, 0);
      drive_dvd(1'b0, '0);
      drive_dvs(1'b0, '0);
      e = cyc;
   endtask

   task automatic send_gap(input logic [31:0] a, input logic [31:0] b, input int gap, output int e);
      drive_dvd(1'b1, a);
      check("gap_rdy_idle", readys(), 4'hF);
      @(posedge clk); #1;
      drive_dvd(1'b0, '0);
      for (int i = 0; i < gap - 1; i++) begin
         check("gap_rdy_held", readys(), 4'b0101);
         @(posedge clk); #1;
      end
      drive_dvs(1'b1, b);
      check("gap_rdy_last", readys(), 4'b0101);
      @(posedge clk); #1;
      e = cyc;
      drive_dvs(1'b0, '0);
   endtask

   task automatic wait_result(input logic [63:0] exp_u, input logic [63:0] exp_s, input int e,
                              input string tag, output int tv);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valids() != 2'b00) begin
            tv = cyc;
            check({tag, "_lat"}, cyc - e, 32);
            check({tag, "_both"}, valids(), 2'b11);
            check({tag, "_u"}, u_if.m_axis_dout_tdata, exp_u);
            check({tag, "_s"}, s_if.m_axis_dout_tdata, exp_s);
            check({tag, "_rdy_done"}, readys(), 4'h0);
            return;
         end
         check({tag, "_rdy_calc"}, readys(), 4'h0);
      end
      check({tag, "_timeout"}, 1, 0);
      tv = cyc;
   endtask

   task automatic pulse_end(input string tag);
      @(posedge clk); #1;
      check(tag, valids(), 2'b00);
   endtask

   task automatic expect_quiet(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (valids() != 2'b00) seen = 1'b1;
      end
      check(tag, seen, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          e, tv, tv1, tv2, gap;
      logic [31:0] a, b;

      reset = 1'b1;
      flush = 1'b0;
      drive_dvd(1'b0, '0);
      drive_dvs(1'b0, '0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", readys(), 4'h0);
      check("rst_valid", valids(), 2'b00);
      check("rst_data_u", u_if.m_axis_dout_tdata, 64'h0);
      check("rst_data_s", s_if.m_axis_dout_tdata, 64'h0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", readys(), 4'hF);

      send_both(32'd100, 32'd7, e);
      wait_result(64'h0000000E_00000002, 64'h0000000E_00000002, e, "d100_7", tv);
      pulse_end("d100_7_pulse");

      send_gap(32'hFFFF_FFF9, 32'd2, 5, e);
      wait_result(ref_div(32'hFFFF_FFF9, 32'd2, 0), 64'hFFFFFFFD_FFFFFFFF, e, "m7_2", tv);
      pulse_end("m7_2_pulse");

      send_both(32'd5, 32'd0, e);
      wait_result(64'hFFFFFFFF_00000005, ref_div(32'd5, 32'd0, 1), e, "div0", tv);

      send_both(32'h8000_0000, 32'hFFFF_FFFF, e);
      wait_result(ref_div(32'h8000_0000, 32'hFFFF_FFFF, 0), 64'h80000000_00000000, e, "ovf", tv);

      send_both(32'd7, 32'hFFFF_FFFE, e);
      wait_result(ref_div(32'd7, 32'hFFFF_FFFE, 0), 64'hFFFFFFFD_00000001, e, "p7_m2", tv);

      send_both(32'd100, 32'd7, e);
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      expect_quiet("flush_quiet", 40);

      drive_dvd(1'b1, 32'd77);
      flush = 1'b1;
      check("flush_rdy_reads1", readys(), 4'hF);
      @(posedge clk); #1;
      flush = 1'b0;
      drive_dvd(1'b0, '0);
      check("flush_drop", readys(), 4'hF);

      send_both(32'd9, 32'd3, e);
      wait_result(64'h00000003_00000000, 64'h00000003_00000000, e, "d9_3", tv);

      send_both(32'd1234567, 32'd89, e);
      repeat (15) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrst_rdy0", readys(), 4'h0);
      check("midrst_valid", valids(), 2'b00);
      @(posedge clk); #1;
      check("midrst_rdy1", readys(), 4'h0);
      reset = 1'b0;
      #1;
      check("midrst_rdy_rel", readys(), 4'hF);
      expect_quiet("midrst_quiet", 40);
      send_both(32'hFFFF_FFCE, 32'd7, e);
      wait_result(ref_div(32'hFFFF_FFCE, 32'd7, 0), 64'hFFFFFFF9_FFFFFFFF, e, "after_rst", tv);

      send_both(32'd40, 32'd6, e);
      wait_result(ref_div(32'd40, 32'd6, 0), ref_div(32'd40, 32'd6, 1), e, "b2b_1", tv1);
      send_both(32'd1000, 32'd33, e);
      check("b2b_accept", e - tv1, 2);
      wait_result(ref_div(32'd1000, 32'd33, 0), ref_div(32'd1000, 32'd33, 1), e, "b2b_2", tv2);
      check("b2b_spacing", tv2 - tv1, 34);

      for (int n = 0; n < 24; n++) begin
         a = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 15);
            2:       b = -$urandom_range(1, 15);
            default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
         endcase
         gap = $urandom_range(0, 3);
         if (gap == 0) send_both(a, b, e);
         else          send_gap(a, b, gap, e);
         wait_result(ref_div(a, b, 0), ref_div(a, b, 1), e, "rnd", tv);
         pulse_end("rnd_pulse");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
